key_scan: RTL and testbench

4x4 matrix keypad scanner for the board's key pad: the input-side counterpart to the seven-segment/LED scan output path. It drives one column low at a time, samples the row lines through a synchronizer, debounces the press, and emits a 4-bit key code with a one-cycle strobe. Its output feeds the timer/display logic as a digit source.

---
 rtl/key_scan.sv | 177 +++++++++++++++++
 tb/tb_key_scan.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan.sv
// key_scan: 4x4 keypad scanner, one column driven low at a time.
// Ports: clk; reset (async, active low); row[3:0] (active-low, async)
//   -> col[3:0], key_code[3:0] {row,col}, key_valid strobe, key_down.
// Optional auto-repeat of key_valid while held: define KEY_REPEAT_EN.
module key_scan #(
  parameter int SCAN_DIV     = 4096,
  parameter int DEBOUNCE_CNT = 65536,
  parameter int REPEAT_CNT   = 8388608
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [SW-1:0] SC_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CNT - 1);
  // HOLD already saw the first high sample, so RELEASE needs one fewer.
  localparam logic [DW-1:0] DB_REL = DW'(DEBOUNCE_CNT - 2);
`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CNT - 1);
`endif

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_CNT < 2) begin : g_bad
    $error("key_scan: parameter out of range");
  end

  typedef enum logic [1:0] {
    SCAN, DEBOUNCE, HOLD, RELEASE
  } state_t;

  state_t        state, state_n;
  logic [3:0]    s1, rs;
  logic [1:0]    ci, ci_n;
  logic [1:0]    ri, ri_n;
  logic [1:0]    lo;
  logic [SW-1:0] dwell, dwell_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [3:0]    code_n;
  logic          valid_n, down_n;
  logic          up;
`ifdef KEY_REPEAT_EN
  logic [RW-1:0] rcnt, rcnt_n;
`endif

  assign col = ~(4'b0001 << ci);
  assign up  = rs[ri];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 4'b1111;
      rs <= 4'b1111;
    end else begin
      s1 <= row;
      rs <= s1;
    end
  end

  // lowest low row wins when several keys share the column
  always_comb begin
    lo = 2'd3;
    if (!rs[2]) lo = 2'd2;
    if (!rs[1]) lo = 2'd1;
    if (!rs[0]) lo = 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      ci        <= 2'd0;
      ri        <= 2'd0;
      dwell     <= '0;
      dcnt      <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rcnt      <= '0;
`endif
    end else begin
      state     <= state_n;
      ci        <= ci_n;
      ri        <= ri_n;
      dwell     <= dwell_n;
      dcnt      <= dcnt_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_down  <= down_n;
`ifdef KEY_REPEAT_EN
      rcnt      <= rcnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    ci_n    = ci;
    ri_n    = ri;
    dwell_n = dwell;
    dcnt_n  = dcnt;
    code_n  = key_code;
    valid_n = 1'b0;
    down_n  = key_down;
`ifdef KEY_REPEAT_EN
    rcnt_n  = rcnt;
`endif
    unique case (state)
      SCAN: begin
        if (dwell == SC_LAST) begin
          dwell_n = '0;
          if (rs != 4'b1111) begin
            ri_n    = lo;
            dcnt_n  = '0;
            state_n = DEBOUNCE;
          end else begin
            ci_n = ci + 2'd1;
          end
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (up) begin
          dwell_n = '0;
          state_n = SCAN;
        end else if (dcnt == DB_LAST) begin
          code_n  = {ri, ci};
          valid_n = 1'b1;
          down_n  = 1'b1;
          state_n = HOLD;
`ifdef KEY_REPEAT_EN
          rcnt_n  = '0;
`endif
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      HOLD: begin
        if (up) begin
          dcnt_n  = '0;
          state_n = RELEASE;
        end
`ifdef KEY_REPEAT_EN
        else if (rcnt == RP_LAST) begin
          valid_n = 1'b1;
          rcnt_n  = '0;
        end else begin
          rcnt_n = rcnt + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (!up) begin
          state_n = HOLD;
        end else if (dcnt == DB_REL) begin
          down_n  = 1'b0;
          ci_n    = ci + 2'd1;
          dwell_n = '0;
          state_n = SCAN;
`ifdef KEY_REPEAT_EN
          rcnt_n  = '0;
`endif
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: keypad-matrix model driving key_scan; scoreboard of
// expected key codes checked on every key_valid strobe.
module tb_key_scan;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RP = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys = '0;

  int         tests = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic       prev_valid = 1'b0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
    logic [1:0]  c;
  } vec_t;

  vec_t tbl[6];

  key_scan #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CNT(DB),
    .REPEAT_CNT(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  // key (r,c) is bit r*4+c; a row reads low only while its column is driven
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      if ((keys[r*4 +: 4] & ~col) != 4'h0) row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [3:0] e;
    if (key_valid === 1'b1) begin
      chk("strobe_not_back_to_back", prev_valid, 0);
      chk("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("strobe_code", key_code, e);
      end
    end
    prev_valid = key_valid;
  end

  task automatic wait_strobe(input string name, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (key_valid !== 1'b1 && lat < 100);
    chk(name, key_valid, 1);
  endtask

  task automatic wait_release(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (key_down !== 1'b0 && n < 100);
  endtask

  task automatic wait_col(input logic [3:0] v);
    int n;
    n = 0;
    while (col == v && n < 64) begin
      @(negedge clk);
      n++;
    end
    while (col != v && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_col", col, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int n;
    int drops;
    int pos[$];
    logic [3:0] ec;
    logic [1:0] nc;

    tbl[0] = '{16'h0200, 4'h9, 2'd1};
    tbl[1] = '{16'h0008, 4'h3, 2'd3};
    tbl[2] = '{16'h1010, 4'h4, 2'd0};
    tbl[3] = '{16'h4000, 4'hE, 2'd2};
    tbl[4] = '{16'h0220, 4'h5, 2'd1};
    tbl[5] = '{16'h8000, 4'hF, 2'd3};

    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_col", col, 4'b1110);
    chk("rst_code", key_code, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_down", key_down, 0);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      nc = 2'((k / 4) % 4);
      ec = ~(4'b0001 << nc);
      chk("scan_step", col, ec);
    end

    for (int i = 0; i < 6; i++) begin
      keys = tbl[i].keys;
      exp_q.push_back(tbl[i].code);
      wait_strobe("tbl_strobe", lat);
      ec = ~(4'b0001 << tbl[i].c);
      chk("tbl_down", key_down, 1);
      chk("tbl_col_frozen", col, ec);
      repeat (20) @(negedge clk);
      chk("tbl_col_held", col, ec);
      chk("tbl_down_held", key_down, 1);
      keys = '0;
      wait_release(n);
      // 2 synchronizer cycles + DB stable cycles
      chk("tbl_release_lat", n, 2 + DB);
      nc = tbl[i].c + 2'd1;
      ec = ~(4'b0001 << nc);
      chk("tbl_next_col", col, ec);
    end

    wait_col(4'b0111);
    keys = 16'h0008;
    repeat (5) @(negedge clk);
    keys = '0;
    repeat (2) @(negedge clk);
    chk("bounce_no_down", key_down, 0);
    exp_q.push_back(4'h3);
    keys = 16'h0008;
    wait_strobe("bounce_strobe", lat);
    chk("bounce_min_lat", lat >= 2 + DB, 1);
    keys = '0;
    wait_release(n);
    chk("bounce_released", key_down, 0);

    keys = 16'h0010;
    exp_q.push_back(4'h4);
    wait_strobe("lock_strobe", lat);
    keys = 16'h4010;
    repeat (20) @(negedge clk);
    chk("lock_down", key_down, 1);
    chk("lock_col", col, 4'b1110);
    keys = '0;
    wait_release(n);
    chk("lock_release_lat", n, 2 + DB);

    keys = 16'h0001;
    exp_q.push_back(4'h0);
    wait_strobe("rpt_accept", lat);
`ifdef KEY_REPEAT_EN
    repeat (3) exp_q.push_back(4'h0);
`endif
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (key_valid === 1'b1) pos.push_back(k);
    end
    keys = '0;
`ifdef KEY_REPEAT_EN
    chk("rpt_count", pos.size(), 3);
    if (pos.size() == 3) begin
      chk("rpt_pos1", pos[0], RP);
      chk("rpt_pos2", pos[1], 2 * RP);
      chk("rpt_pos3", pos[2], 3 * RP);
    end
`else
    chk("rpt_none", pos.size(), 0);
`endif
    wait_release(n);
    chk("rpt_release_lat", n, 2 + DB);

    keys = 16'h0040;
    exp_q.push_back(4'h6);
    wait_strobe("glitch_strobe", lat);
    repeat (5) @(negedge clk);
    keys = '0;
    repeat (3) @(negedge clk);
    keys = 16'h0040;
    drops = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (key_down !== 1'b1) drops++;
    end
    chk("glitch_down_held", drops, 0);
    keys = '0;
    wait_release(n);
    chk("glitch_release_lat", n, 2 + DB);

    wait_col(4'b1110);
    keys = 16'h0100;
    repeat (6) @(negedge clk);
    chk("pre_reset_code", key_code, 4'h6);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_col", col, 4'b1110);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_down", key_down, 0);
    keys = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_down", key_down, 0);
    chk("post_rst_code", key_code, 0);

    @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
